// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: PC sequencer state encoding and fetch constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_REDIR = 2'd2
  } seq_state_t;

  localparam int unsigned INST_BYTES       = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC and stall/flush controller for the 5-stage pipeline.
// Define PC_SEQ_PERF_COUNTERS_EN to add stall_cycles/flush_events counters.
module pc_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned       INC      = INST_BYTES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  input  logic             imem_ready,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] next_pc,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush
`ifdef PC_SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events
`endif
);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_pend_target;
  logic [WIDTH-1:0] w_pend_nxt;
  logic             w_redirect;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_seq;

  assign w_redirect = jump | branch_taken;
  assign w_tgt      = jump ? jump_target : branch_target;
  assign w_seq      = pc + WIDTH'(INC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pend_target <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_target;
    imem_req    = 1'b1;
    next_pc     = w_seq;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    if (reset) begin
      imem_req    = 1'b0;
      next_pc     = RESET_PC;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_state_nxt = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH, S_WAIT: begin
          if (load_use_hazard) begin
            // Hold PC and IF/ID; the branch in ID re-resolves once the stall clears.
            id_ex_flush = 1'b1;
            w_state_nxt = imem_ready ? S_FETCH : S_WAIT;
          end else if (w_redirect) begin
            if_id_flush = 1'b1;
            if (imem_ready) begin
              next_pc     = w_tgt;
              pc_write    = 1'b1;
              if_id_write = 1'b1;
              w_state_nxt = S_FETCH;
            end else begin
              w_pend_nxt  = w_tgt;
              w_state_nxt = S_REDIR;
            end
          end else if (imem_ready) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
        S_REDIR: begin
          // Wrong-path word is still in flight; discard it and then take the latched target.
          if_id_flush = 1'b1;
          if (imem_ready) begin
            next_pc     = r_pend_target;
            pc_write    = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end
  end

`ifdef PC_SEQ_PERF_COUNTERS_EN
  logic w_stall_evt;
  logic w_flush_evt;

  assign w_stall_evt = ~pc_write & ~reset;
  // One event per redirect decision; S_REDIR hold cycles are not recounted.
  assign w_flush_evt = ~reset & (r_state != S_REDIR) & ~load_use_hazard & w_redirect;

  sat_counter u_stall_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_en    (w_stall_evt),
    .o_count (stall_cycles)
  );

  sat_counter u_flush_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_en    (w_flush_evt),
    .o_count (flush_events)
  );
`endif

endmodule
